// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the LCD character-RAM arbiter.
// The RAM_ARB_FIXED_PRIO_EN macro selects the tie-break policy inside ram_arb_pick.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic P_WB  = 1'b0;
    localparam logic P_LCD = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester's req/ack channel into the character-RAM arbiter.
// master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the two requesters.
// Round-robin on the last pointer by default; RAM_ARB_FIXED_PRIO_EN makes port 0 always win.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic last_i,
    output logic grant_o,
    output logic valid_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_s;
    assign unused_last_s = last_i;

    // Port 0 always takes priority.
    always_comb begin
        valid_o = p0_req_i | p1_req_i;
        if (p0_req_i) begin
            grant_o = P_WB;
        end else if (p1_req_i) begin
            grant_o = P_LCD;
        end else begin
            grant_o = P_WB;
        end
    end
`else
    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        valid_o = p0_req_i | p1_req_i;
        if (p0_req_i && p1_req_i) begin
            grant_o = ~last_i;
        end else if (p1_req_i) begin
            grant_o = P_LCD;
        end else begin
            grant_o = P_WB;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the 256x8 LCD character RAM (IDLE->ISSUE->WAIT->ACK).
// Tie-break policy is selected by RAM_ARB_FIXED_PRIO_EN (see ram_arb_pick).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk2,
    input  logic              rst,
    ram_arbiter_if.slave      p0,
    ram_arbiter_if.slave      p1,
    output logic              ram_rd,
    output logic              ram_wr1,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_dbin1,
    input  logic [DATA_W-1:0] ram_dbout1
);

    state_e            state_q;
    logic              last_q;
    logic              cmd_port_q;
    logic              cmd_we_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              ram_rd_q, ram_wr1_q;
    logic [ADDR_W-1:0] ram_addr1_q, ram_addr2_q;
    logic [DATA_W-1:0] ram_dbin1_q;

    logic              grant_s, valid_s;
    logic              cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_d;

    ram_arb_pick u_pick (
        .p0_req_i (p0.req),
        .p1_req_i (p1.req),
        .last_i   (last_q),
        .grant_o  (grant_s),
        .valid_o  (valid_s)
    );

    // Route the winning port's command toward the command register.
    always_comb begin
        cmd_we_d    = p0.we;
        cmd_addr_d  = p0.addr;
        cmd_wdata_d = p0.wdata;
        if (grant_s == P_LCD) begin
            cmd_we_d    = p1.we;
            cmd_addr_d  = p1.addr;
            cmd_wdata_d = p1.wdata;
        end else begin
            cmd_we_d    = p0.we;
            cmd_addr_d  = p0.addr;
            cmd_wdata_d = p0.wdata;
        end
    end

    // Sequencer FSM; strobes are loaded on the IDLE->ISSUE edge so they are high for exactly the ISSUE cycle.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            ram_rd_q    <= 1'b0;
            ram_wr1_q   <= 1'b0;
            ram_addr1_q <= {ADDR_W{1'b0}};
            ram_addr2_q <= {ADDR_W{1'b0}};
            ram_dbin1_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_s) begin
                        state_q    <= ISSUE;
                        cmd_port_q <= grant_s;
                        cmd_we_q   <= cmd_we_d;
                        last_q     <= grant_s;
                        ram_rd_q   <= ~cmd_we_d;
                        ram_wr1_q  <= cmd_we_d;
                        if (cmd_we_d) begin
                            ram_addr1_q <= cmd_addr_d;
                            ram_dbin1_q <= cmd_wdata_d;
                        end else begin
                            ram_addr2_q <= cmd_addr_d;
                        end
                    end
                end
                ISSUE: begin
                    ram_rd_q  <= 1'b0;
                    ram_wr1_q <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // RAM output is valid now, one cycle after the read strobe.
                    if (!cmd_we_q) begin
                        if (cmd_port_q == P_LCD) begin
                            rdata1_q <= ram_dbout1;
                        end else begin
                            rdata0_q <= ram_dbout1;
                        end
                    end
                    ack0_q  <= (cmd_port_q == P_WB);
                    ack1_q  <= (cmd_port_q == P_LCD);
                    state_q <= ACK;
                end
                ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack0_q    <= 1'b0;
                    ack1_q    <= 1'b0;
                    ram_rd_q  <= 1'b0;
                    ram_wr1_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign p0.ack     = ack0_q;
    assign p1.ack     = ack1_q;
    assign p0.rdata   = rdata0_q;
    assign p1.rdata   = rdata1_q;
    assign ram_rd     = ram_rd_q;
    assign ram_wr1    = ram_wr1_q;
    assign ram_addr1  = ram_addr1_q;
    assign ram_addr2  = ram_addr2_q;
    assign ram_dbin1  = ram_dbin1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural registered RAM, shadow memory and ack scoreboard.
module tb_ram_arbiter;

    typedef struct {
        int         port;
        logic       is_rd;
        logic [7:0] data;
    } exp_t;

    logic       clk2 = 1'b0;
    logic       rst  = 1'b0;
    logic       ram_rd, ram_wr1;
    logic [7:0] ram_addr1, ram_addr2, ram_dbin1;
    logic [7:0] ram_dbout1 = 8'h00;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p0_if ();
    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p1_if ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .p0         (p0_if),
        .p1         (p1_if),
        .ram_rd     (ram_rd),
        .ram_wr1    (ram_wr1),
        .ram_addr1  (ram_addr1),
        .ram_addr2  (ram_addr2),
        .ram_dbin1  (ram_dbin1),
        .ram_dbout1 (ram_dbout1)
    );

    always #5 clk2 = ~clk2;

    int   checks = 0;
    int   errors = 0;
    int   wr1_cycles = 0;
    exp_t sb[$];
    logic [7:0] mem    [256];
    logic [7:0] shadow [256];

    // Stand-in for the power-on file contents of the character RAM.
    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'(a * 7 + 19);
        return v;
    endfunction

    // Registered-read RAM, reloaded under reset.
    always @(posedge clk2) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            ram_dbout1 <= 8'h00;
        end else begin
            if (ram_wr1) mem[ram_addr1] <= ram_dbin1;
            if (ram_rd) ram_dbout1 <= mem[ram_addr2];
        end
    end

    // Scoreboard and strobe monitor, sampled away from the active edge.
    always @(negedge clk2) begin
        exp_t e;
        checks++;
        if (ram_rd === 1'b1 && ram_wr1 === 1'b1) begin
            errors++;
            $display("FAIL strobe_excl: ram_rd=%b ram_wr1=%b required not both 1", ram_rd, ram_wr1);
        end
        if (ram_wr1 === 1'b1) wr1_cycles++;
        if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) begin
            checks++;
            if (p0_if.ack === 1'b1 && p1_if.ack === 1'b1) begin
                errors++;
                $display("FAIL ack_excl: both acks high");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: p0_ack=%b p1_ack=%b required none", p0_if.ack, p1_if.ack);
            end else begin
                e = sb.pop_front();
                if ((p1_if.ack === 1'b1 ? 1 : 0) !== e.port) begin
                    errors++;
                    $display("FAIL ack_port: got port %0d required port %0d", (p1_if.ack === 1'b1 ? 1 : 0), e.port);
                end else if (e.is_rd && e.port == 0 && p0_if.rdata !== e.data) begin
                    errors++;
                    $display("FAIL p0_rdata: got %h required %h", p0_if.rdata, e.data);
                end else if (e.is_rd && e.port == 1 && p1_if.rdata !== e.data) begin
                    errors++;
                    $display("FAIL p1_rdata: got %h required %h", p1_if.rdata, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.port  = p;
        e.is_rd = ~we;
        e.data  = we ? 8'h00 : shadow[a];
        if (we) shadow[a] = d;
        sb.push_back(e);
        if (p == 0) begin
            p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
        end else begin
            p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
        end
    endtask

    task automatic release_req(input int p);
        if (p == 0) p0_if.req = 1'b0;
        else        p1_if.req = 1'b0;
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? p0_if.ack : p1_if.ack;
    endfunction

    task automatic wait_ack(input int p, input string name, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack_of(p) !== 1'b1 && lat < 30);
        if (ack_of(p) !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no ack on port %0d within 30 cycles", name, p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_if.req = 1'b0;
        p1_if.req = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete transaction with latency check; req dropped the cycle after ack.
    task automatic xact(input int p, input logic we, input logic [7:0] a, input logic [7:0] d, input string name);
        int lat;
        drive(p, we, a, d);
        wait_ack(p, name, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL %s_latency: got %0d required 3", name, lat);
        end
        tick();
        release_req(p);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({p0_if.ack, p1_if.ack, ram_rd, ram_wr1} !== 4'b0000 ||
            {ram_addr1, ram_addr2, ram_dbin1} !== 24'h000000 ||
            {p0_if.rdata, p1_if.rdata} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_vals: acks=%b%b rd=%b wr=%b a1=%h a2=%h din=%h r0=%h r1=%h required all 0",
                     p0_if.ack, p1_if.ack, ram_rd, ram_wr1, ram_addr1, ram_addr2, ram_dbin1, p0_if.rdata, p1_if.rdata);
        end
    endtask

    task automatic test_write_read();
        wr1_cycles = 0;
        xact(0, 1'b1, 8'h10, 8'hA5, "wr10");
        checks++;
        if (wr1_cycles !== 1) begin
            errors++;
            $display("FAIL wr1_pulse: got %0d cycles required 1", wr1_cycles);
        end
        checks++;
        if (ram_addr1 !== 8'h10 || ram_dbin1 !== 8'hA5) begin
            errors++;
            $display("FAIL wr_hold: addr1=%h dbin1=%h required 10 a5", ram_addr1, ram_dbin1);
        end
        xact(0, 1'b0, 8'h10, 8'h00, "rd10");
        checks++;
        if (p0_if.rdata !== 8'hA5) begin
            errors++;
            $display("FAIL rd10_value: got %h required a5", p0_if.rdata);
        end
    endtask

    task automatic test_simultaneous();
        int l0, l1;
        do_reset();
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h01, 8'h00);
        wait_ack(0, "sim_p0", l0);
        checks++;
        if (l0 !== 3) begin
            errors++;
            $display("FAIL sim_p0_first: p0 ack after %0d cycles required 3", l0);
        end
        tick();
        release_req(0);
        wait_ack(1, "sim_p1", l1);
        checks++;
        if (l1 !== 3) begin
            errors++;
            $display("FAIL sim_p1_gap: p1 ack %0d cycles after p0 ack required 4", l1 + 1);
        end
        tick();
        release_req(1);
    endtask

    task automatic test_contention();
        int   issued [2];
        int   acked;
        logic pend_drop [2];
        logic raise_nx  [2];
        do_reset();
        acked = 0;
        for (int p = 0; p < 2; p++) begin
            pend_drop[p] = 1'b0;
            raise_nx[p]  = 1'b0;
        end
        drive(0, 1'b1, 8'h40, 8'h11);
        drive(1, 1'b0, 8'h80, 8'h00);
        issued[0] = 1;
        issued[1] = 1;
        for (int c = 0; c < 200 && acked < 16; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (raise_nx[p]) begin
                    raise_nx[p] = 1'b0;
                    if (issued[p] < 8) begin
                        if (p == 0) drive(0, 1'b1, 8'(8'h40 + issued[0]), 8'(issued[0] * 3));
                        else        drive(1, 1'b0, 8'(8'h80 + issued[1]), 8'h00);
                        issued[p]++;
                    end
                end
                if (pend_drop[p]) begin
                    pend_drop[p] = 1'b0;
                    release_req(p);
                    raise_nx[p] = 1'b1;
                end
                if (ack_of(p) === 1'b1) begin
                    acked++;
                    pend_drop[p] = 1'b1;
                end
            end
        end
        tick();
        release_req(0);
        release_req(1);
        checks++;
        if (acked !== 16 || sb.size() !== 0) begin
            errors++;
            $display("FAIL contention_count: acks=%0d pending=%0d required 16 and 0", acked, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1'b0, 8'h01, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        release_req(1);
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        sb.delete();
        tick();
        rst = 1'b0;
        checks++;
        if ({p0_if.ack, p1_if.ack, ram_rd, ram_wr1} !== 4'b0000 ||
            {ram_addr1, ram_addr2, ram_dbin1, p0_if.rdata, p1_if.rdata} !== 40'h0) begin
            errors++;
            $display("FAIL midrst_outputs: p1_ack=%b rd=%b wr=%b a2=%h r1=%h required all 0",
                     p1_if.ack, ram_rd, ram_wr1, ram_addr2, p1_if.rdata);
        end
        for (int i = 0; i < 5; i++) tick();
        xact(1, 1'b0, 8'h01, 8'h00, "midrst_rd01");
        xact(0, 1'b0, 8'h10, 8'h00, "midrst_rd10");
    endtask

    task automatic test_req_held();
        int lat;
        drive(1, 1'b0, 8'h20, 8'h00);
        drive(1, 1'b0, 8'h20, 8'h00);
        wait_ack(1, "held_first", lat);
        tick();
        tick();
        checks++;
        if (ram_rd !== 1'b1 || ram_addr2 !== 8'h20) begin
            errors++;
            $display("FAIL held_reissue: ram_rd=%b addr2=%h required 1 20", ram_rd, ram_addr2);
        end
        tick();
        release_req(1);
        wait_ack(1, "held_second", lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL held_second_time: got %0d required 1", lat);
        end
        tick();
    endtask

    task automatic test_isolation();
        int l0, l1;
        do_reset();
        drive(0, 1'b1, 8'h30, 8'h5A);
        drive(1, 1'b0, 8'h31, 8'h00);
        wait_ack(0, "iso_p0", l0);
        tick();
        release_req(0);
        wait_ack(1, "iso_p1", l1);
        checks++;
        if (p1_if.rdata !== init_val(8'h31)) begin
            errors++;
            $display("FAIL iso_p1_rdata: got %h required %h", p1_if.rdata, init_val(8'h31));
        end
        tick();
        release_req(1);
        xact(1, 1'b0, 8'h30, 8'h00, "iso_rd30");
        checks++;
        if (p1_if.rdata !== 8'h5A) begin
            errors++;
            $display("FAIL iso_rd30_value: got %h required 5a", p1_if.rdata);
        end
    endtask

    initial begin
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 8'h00; p0_if.wdata = 8'h00;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 8'h00; p1_if.wdata = 8'h00;
        tick();
        test_reset();
        test_write_read();
        test_simultaneous();
        test_contention();
        test_reset_mid();
        test_req_held();
        test_isolation();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected acks never seen, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the 256×8 LCD character RAM in `wb_lcd`. It shares the RAM between two requesters:
- port 0: Wishbone-side writer/reader;
- port 1: LCD refresh reader.

Only one RAM strobe (`ram_rd` or `ram_wr1`) is ever high in a given cycle. Each transaction is a fixed 4-cycle req/ack sequence, and the RAM's registered read latency is hidden behind a captured `rdata` register.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width

Ports (one clock; reset is synchronous and active-high):
- clk2  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset; also drives RAM `rst` at top level
- p0_req, p1_req  in  1  request, held high until ack
- p0_we, p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr, p1_addr  in  ADDR_W  address; stable while req high
- p0_wdata, p1_wdata  in  DATA_W  write data; stable while req high
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DATA_W  read data, valid when ack high, held until next read on that port
- ram_rd  out  1  RAM read strobe
- ram_wr1  out  1  RAM write strobe
- ram_addr1  out  ADDR_W  RAM write address
- ram_addr2  out  ADDR_W  RAM read address
- ram_dbin1  out  DATA_W  RAM write data
- ram_dbout1  in  DATA_W  RAM registered read data

## Operation
- FSM states and transitions: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE: if any req is high, latch the winner's index, we, addr and wdata into the command register, then go to ISSUE. Otherwise stay.
- Arbitration:
  - Round-robin with a 1-bit `last` pointer.
  - One req high: grant it.
  - Both high: grant the port ≠ `last`.
  - `last` updates on every grant.
- ISSUE: drive exactly one strobe from the command register.
  - Read: `ram_rd`=1, `ram_addr2`=addr.
  - Write: `ram_wr1`=1, `ram_addr1`=addr, `ram_dbin1`=wdata.
- WAIT: all strobes low. For a read, load the granted port's `rdata` register from `ram_dbout1` at the end of this cycle.
- ACK: pulse the granted port's ack for one cycle. The other port's ack stays 0.
- Requester contract: drop req in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- req falling before ack: the transaction already latched completes normally and ack is still pulsed.
- Address/data outputs hold the last command value when strobes are low. `ram_rd` and `ram_wr1` are never both 1.

## Timing
- Latency: req sampled high at edge E → ISSUE in cycle E+1 → WAIT in E+2 → ack high in E+3.
- Sustained throughput: one transaction per 4 cycles. Two contending ports alternate, each served every 8 cycles.
- Reset values (rst high at an edge):
  - state = IDLE, `last` = 1 (port 0 wins first tie);
  - all acks, `ram_rd`, `ram_wr1` = 0;
  - addr/data outputs and both rdata registers = 0.
- Reset mid-transaction: abort immediately, with no ack and no strobe in the following cycle. Because the RAM reloads its contents under the same reset, the aborted write is lost.
- Req sampled during ISSUE, WAIT or ACK: ignored until IDLE.

## Configuration
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins ties, and `last` is not implemented. Port 1 can starve if port 0 requests back-to-back.
- Undefined (default): round-robin as described above.

## Structure
- Package `ram_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, ACK);
  - ADDR_W and DATA_W defaults;
  - port index constants P_WB=0 and P_LCD=1.
- Sub-module `ram_arb_pick`: combinational winner select from {p0_req, p1_req, last}, outputs grant index and valid. The macro applies only inside `ram_arb_pick`.
- FSM, command register and rdata registers live in `ram_arbiter`.

## Test plan
- Single write then read: p0 write addr 0x10 data 0xA5, then p0 read 0x10.
  - Response: each ack 3 cycles after req is sampled; `p0_rdata`=0xA5; `ram_wr1` high exactly one cycle.
- Simultaneous requests after reset: p0 read 0x00 and p1 read 0x01.
  - Response: p0 acked first, then p1 acked 4 cycles later.
  - With RAM_ARB_FIXED_PRIO_EN and p0 re-requesting, p0 wins again.
- Continuous contention, 16 transactions: acks alternate p0/p1. Assert `ram_rd` & `ram_wr1` never both 1.
- rst during WAIT of a p1 read:
  - no p1_ack;
  - all outputs 0 the next cycle;
  - RAM reloaded from `lista.txt`;
  - next read of 0x01 returns the file value.
- req held through ack: p1 read 0x20 with req kept high for 2 cycles after ack.
  - Response: a second ISSUE of 0x20 starts in the IDLE→ISSUE cycle and completes with a second ack.
- Write/read isolation: p0 write 0x30=0x5A while p1 reads 0x31.
  - Response: p1_rdata is the initial value at 0x31 and is unaffected by p0_wdata.
